accel_tilt_filter: RTL and testbench

ACCEL_TILT_FILTER -- requirements
Module: accel_tilt_filter

---
 rtl/accel_tilt_filter.sv | 199 +++++++++++++++++++
 tb/tb_accel_tilt_filter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/accel_tilt_filter.sv
// Accelerometer tilt filter: boxcar-averages 2^AVG_LOG2 samples per axis,
// then classifies X/Y tilt direction with hysteresis and a flat detector.

// Per-axis direction update (NEG/ZERO/POS) with hysteresis on the way back to ZERO.
module accel_tilt_axis #(
   parameter logic [11:0] TILT_THRESH = 12'd256,
   parameter logic [11:0] TILT_HYST   = 12'd32
) (
   input  logic [11:0] avg,
   input  logic [1:0]  dir,
   output logic [1:0]  dir_nxt
);
   localparam logic [1:0] DIR_ZERO = 2'd0;
   localparam logic [1:0] DIR_POS  = 2'd1;
   localparam logic [1:0] DIR_NEG  = 2'd2;

   // 13-bit signed so that negating any 12-bit threshold cannot overflow
   localparam logic signed [12:0] THR_P = $signed({1'b0, TILT_THRESH});
   localparam logic signed [12:0] THR_N = -THR_P;
   localparam logic signed [12:0] LOW_P = $signed({1'b0, TILT_THRESH}) - $signed({1'b0, TILT_HYST});
   localparam logic signed [12:0] LOW_N = -LOW_P;

   logic signed [12:0] a;
   assign a = $signed({avg[11], avg});

   // Next direction; an opposite-threshold crossing jumps straight across
   always_comb begin
      dir_nxt = dir;
      case (dir)
         DIR_POS: begin
            if (a < THR_N)      dir_nxt = DIR_NEG;
            else if (a < LOW_P) dir_nxt = DIR_ZERO;
         end
         DIR_NEG: begin
            if (a > THR_P)      dir_nxt = DIR_POS;
            else if (a > LOW_N) dir_nxt = DIR_ZERO;
         end
         default: begin
            if (a > THR_P)      dir_nxt = DIR_POS;
            else if (a < THR_N) dir_nxt = DIR_NEG;
            else                dir_nxt = DIR_ZERO;
         end
      endcase
   end
endmodule

module accel_tilt_filter #(
   parameter int          AVG_LOG2    = 3,
   parameter logic [11:0] TILT_THRESH = 12'd256,
   parameter logic [11:0] TILT_HYST   = 12'd32
) (
   input  logic        clk_SPI,
   input  logic        reset,
   input  logic        enable,
   input  logic        sample_valid,
   input  logic [11:0] x_in,
   input  logic [11:0] y_in,
   input  logic [11:0] z_in,
   output logic        sample_ready,
   output logic [11:0] x_avg,
   output logic [11:0] y_avg,
   output logic [11:0] z_avg,
   output logic        avg_valid,
   output logic        tilt_right,
   output logic        tilt_left,
   output logic        tilt_fwd,
   output logic        tilt_back,
   output logic        flat,
   output logic        tilt_change,
   output logic        overrun
);
   localparam int AW = 12 + AVG_LOG2;

   localparam logic [1:0] ACCUM    = 2'd0;
   localparam logic [1:0] DIVIDE   = 2'd1;
   localparam logic [1:0] CLASSIFY = 2'd2;

   localparam logic [1:0] DIR_ZERO = 2'd0;
   localparam logic [1:0] DIR_POS  = 2'd1;
   localparam logic [1:0] DIR_NEG  = 2'd2;

   localparam logic [AVG_LOG2-1:0] CNT_ONE  = 1;
   localparam logic [AVG_LOG2-1:0] CNT_LAST = '1;

   logic [1:0]               state_q, state_d;
   logic [AVG_LOG2-1:0]      count_q, count_d;
   logic [2:0][AW-1:0]       acc_q, acc_d;
   logic [2:0][11:0]         avg_q, avg_d;
   logic [2:0][11:0]         smp;
   logic [1:0][1:0]          dir_q, dir_d, dir_nxt;
   logic [4:0]               flag_q, flag_d, flag_nxt;
   logic                     avg_valid_q, avg_valid_d;
   logic                     tilt_change_q, tilt_change_d;
   logic                     overrun_q, overrun_d;
   logic                     z_pos;

   assign smp = {z_in, y_in, x_in};

   // X and Y share the same direction logic; index 0 = X, 1 = Y
   for (genvar g = 0; g < 2; g++) begin : g_axis
      accel_tilt_axis #(
         .TILT_THRESH (TILT_THRESH),
         .TILT_HYST   (TILT_HYST)
      ) u_axis (
         .avg     (avg_q[g]),
         .dir     (dir_q[g]),
         .dir_nxt (dir_nxt[g])
      );
   end

   assign z_pos    = !avg_q[2][11] && (avg_q[2] != 12'd0);
   // {flat, back, fwd, left, right}
   assign flag_nxt = {(dir_nxt[0] == DIR_ZERO) && (dir_nxt[1] == DIR_ZERO) && z_pos,
                      dir_nxt[1] == DIR_NEG, dir_nxt[1] == DIR_POS,
                      dir_nxt[0] == DIR_NEG, dir_nxt[0] == DIR_POS};

   // Accumulate / divide / classify sequencing and drop detection
   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      acc_d         = acc_q;
      avg_d         = avg_q;
      dir_d         = dir_q;
      flag_d        = flag_q;
      avg_valid_d   = 1'b0;
      tilt_change_d = 1'b0;
      overrun_d     = overrun_q | (sample_valid & enable & (state_q != ACCUM));
      case (state_q)
         ACCUM: begin
            if (!enable) begin
               acc_d   = '0;
               count_d = '0;
            end else if (sample_valid) begin
               for (int i = 0; i < 3; i++)
                  acc_d[i] = acc_q[i] + {{AVG_LOG2{smp[i][11]}}, smp[i]};
               if (count_q == CNT_LAST) begin
                  count_d = '0;
                  state_d = DIVIDE;
               end else begin
                  count_d = count_q + CNT_ONE;
               end
            end
         end
         DIVIDE: begin
            // Dropping the low bits of a two's-complement sum floors toward -inf
            for (int i = 0; i < 3; i++)
               avg_d[i] = acc_q[i][AW-1:AVG_LOG2];
            acc_d   = '0;
            state_d = CLASSIFY;
         end
         CLASSIFY: begin
            dir_d         = dir_nxt;
            flag_d        = flag_nxt;
            avg_valid_d   = 1'b1;
            tilt_change_d = (flag_nxt != flag_q);
            state_d       = ACCUM;
         end
         default: state_d = ACCUM;
      endcase
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk_SPI) begin
      if (!reset) begin
         state_q       <= ACCUM;
         count_q       <= '0;
         acc_q         <= '0;
         avg_q         <= '0;
         dir_q         <= {DIR_ZERO, DIR_ZERO};
         flag_q        <= '0;
         avg_valid_q   <= 1'b0;
         tilt_change_q <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         acc_q         <= acc_d;
         avg_q         <= avg_d;
         dir_q         <= dir_d;
         flag_q        <= flag_d;
         avg_valid_q   <= avg_valid_d;
         tilt_change_q <= tilt_change_d;
         overrun_q     <= overrun_d;
      end
   end

   assign sample_ready = (state_q == ACCUM) && enable;
   assign x_avg        = avg_q[0];
   assign y_avg        = avg_q[1];
   assign z_avg        = avg_q[2];
   assign avg_valid    = avg_valid_q;
   assign tilt_change  = tilt_change_q;
   assign overrun      = overrun_q;
   assign tilt_right   = flag_q[0];
   assign tilt_left    = flag_q[1];
   assign tilt_fwd     = flag_q[2];
   assign tilt_back    = flag_q[3];
   assign flat         = flag_q[4];
endmodule

// File: tb/tb_accel_tilt_filter.sv
// Scoreboard bench for accel_tilt_filter: expected averages/flags are queued
// when a round is issued and checked by a monitor on every avg_valid pulse.
module tb_accel_tilt_filter;
   logic        clk_SPI = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b1;
   logic        sample_valid = 1'b0;
   logic [11:0] x_in = '0, y_in = '0, z_in = '0;
   logic        sample_ready, avg_valid, tilt_change, overrun;
   logic        tilt_right, tilt_left, tilt_fwd, tilt_back, flat;
   logic [11:0] x_avg, y_avg, z_avg;

   typedef struct {
      logic [11:0] x, y, z;
      logic [4:0]  flags;   // {flat, back, fwd, left, right}
      logic        chg;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   accel_tilt_filter dut (
      .clk_SPI(clk_SPI), .reset(reset), .enable(enable), .sample_valid(sample_valid),
      .x_in(x_in), .y_in(y_in), .z_in(z_in), .sample_ready(sample_ready),
      .x_avg(x_avg), .y_avg(y_avg), .z_avg(z_avg), .avg_valid(avg_valid),
      .tilt_right(tilt_right), .tilt_left(tilt_left), .tilt_fwd(tilt_fwd),
      .tilt_back(tilt_back), .flat(flat), .tilt_change(tilt_change), .overrun(overrun)
   );

   always #5 clk_SPI = ~clk_SPI;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // Monitor: pop and compare on every avg_valid; tilt_change must never pulse alone
   always @(negedge clk_SPI) begin
      if (avg_valid) begin
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_avg_valid: got avg_valid=1 expected no pending result");
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("x_avg", int'(x_avg), int'(e.x));
            chk("y_avg", int'(y_avg), int'(e.y));
            chk("z_avg", int'(z_avg), int'(e.z));
            chk("flags", int'({flat, tilt_back, tilt_fwd, tilt_left, tilt_right}), int'(e.flags));
            chk("tilt_change", int'(tilt_change), int'(e.chg));
         end
      end else begin
         chk("tilt_change_alone", int'(tilt_change), 0);
      end
   end

   task automatic push(input int ex, input int ey, input int ez, input logic [4:0] fl, input logic c);
      exp_t e;
      e.x = 12'(ex); e.y = 12'(ey); e.z = 12'(ez); e.flags = fl; e.chg = c;
      sb.push_back(e);
   endtask

   task automatic send(input int x, input int y, input int z);
      @(posedge clk_SPI); #1;
      x_in = 12'(x); y_in = 12'(y); z_in = 12'(z); sample_valid = 1'b1;
      @(posedge clk_SPI); #1;
      sample_valid = 1'b0;
   endtask

   // Bounded wait for the result: checks latency (in negedges from now) and pulse width
   task automatic wait_done(input int exp_lat);
      int lat = 0;
      int pulses = 0;
      for (int n = 1; n <= 6; n++) begin
         @(negedge clk_SPI);
         if (avg_valid) begin
            pulses++;
            if (lat == 0) lat = n;
         end
      end
      chk("latency", lat, exp_lat);
      chk("avg_valid_pulses", pulses, 1);
   endtask

   // Seven samples of x7 then one of x8; y/z constant
   task automatic round(input int x7, input int x8, input int y, input int z,
                        input int ex, input int ey, input int ez, input logic [4:0] fl, input logic c);
      push(ex, ey, ez, fl, c);
      for (int i = 0; i < 7; i++) send(x7, y, z);
      send(x8, y, z);
      wait_done(3);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk_SPI);
      #1 reset = 1'b1;
      @(negedge clk_SPI);
      chk("rst_x_avg", int'(x_avg), 0);
      chk("rst_z_avg", int'(z_avg), 0);
      chk("rst_flags", int'({flat, tilt_back, tilt_fwd, tilt_left, tilt_right}), 0);
      chk("rst_avg_valid", int'(avg_valid), 0);
      chk("rst_overrun", int'(overrun), 0);
      chk("rst_sample_ready", int'(sample_ready), 1);

      // Basic tilt right, then rounding/floor edge cases
      round(300, 300, 0, 1000, 300, 0, 1000, 5'b00001, 1'b1);
      round(0, -7, 0, 1000, -1, 0, 1000, 5'b10000, 1'b1);
      round(0, 8, 0, 1000, 1, 0, 1000, 5'b10000, 1'b0);
      round(-2048, -2048, 0, 1000, -2048, 0, 1000, 5'b00010, 1'b1);
      // Hysteresis and direct crossings
      round(300, 300, 0, 1000, 300, 0, 1000, 5'b00001, 1'b1);
      round(240, 240, 0, 1000, 240, 0, 1000, 5'b00001, 1'b0);
      round(220, 220, 0, 1000, 220, 0, 1000, 5'b10000, 1'b1);
      round(300, 300, 0, 1000, 300, 0, 1000, 5'b00001, 1'b1);
      round(-300, -300, 0, 1000, -300, 0, 1000, 5'b00010, 1'b1);
      round(-240, -240, 0, 1000, -240, 0, 1000, 5'b00010, 1'b0);
      round(-220, -220, 0, 1000, -220, 0, 1000, 5'b10000, 1'b1);

      // Sample presented during DIVIDE is dropped and sets sticky overrun
      chk("overrun_before", int'(overrun), 0);
      push(0, 0, 1000, 5'b10000, 1'b0);
      for (int i = 0; i < 7; i++) send(0, 0, 1000);
      @(posedge clk_SPI); #1;
      x_in = 12'd0; y_in = 12'd0; z_in = 12'd1000; sample_valid = 1'b1;
      @(posedge clk_SPI); #1;
      x_in = 12'd800;
      @(posedge clk_SPI); #1;
      sample_valid = 1'b0;
      chk("overrun_set", int'(overrun), 1);
      wait_done(2);
      round(-300, -300, 0, 1000, -300, 0, 1000, 5'b00010, 1'b1);
      chk("overrun_sticky", int'(overrun), 1);

      // Reset during DIVIDE discards the round
      for (int i = 0; i < 8; i++) send(300, 300, 300);
      reset = 1'b0;
      repeat (2) @(posedge clk_SPI);
      #1 reset = 1'b1;
      repeat (4) @(negedge clk_SPI);
      chk("rst_div_x_avg", int'(x_avg), 0);
      chk("rst_overrun_clr", int'(overrun), 0);

      // Reset after five samples, then a clean round
      for (int i = 0; i < 5; i++) send(300, 300, 300);
      reset = 1'b0;
      repeat (2) @(posedge clk_SPI);
      #1 reset = 1'b1;
      round(0, 0, -500, 900, 0, -500, 900, 5'b01000, 1'b1);

      // Enable low mid-round clears partial sums; sample ignored without overrun
      for (int i = 0; i < 4; i++) send(500, 500, -100);
      enable = 1'b0;
      @(posedge clk_SPI); #1;
      sample_valid = 1'b1;
      @(negedge clk_SPI);
      chk("ready_when_disabled", int'(sample_ready), 0);
      @(posedge clk_SPI); #1;
      sample_valid = 1'b0;
      chk("overrun_disabled", int'(overrun), 0);
      chk("y_avg_hold", int'(y_avg), int'(12'hE0C));
      enable = 1'b1;
      round(0, 0, 0, 1000, 0, 0, 1000, 5'b10000, 1'b1);

      // Sample on the CLASSIFY->ACCUM edge is refused
      push(0, 300, 1000, 5'b00100, 1'b1);
      for (int i = 0; i < 8; i++) send(0, 300, 1000);
      @(posedge clk_SPI); #1;
      x_in = 12'd0; y_in = 12'd0; z_in = 12'd0; sample_valid = 1'b1;
      @(negedge clk_SPI);
      chk("ready_in_classify", int'(sample_ready), 0);
      @(posedge clk_SPI); #1;
      sample_valid = 1'b0;
      chk("overrun_classify", int'(overrun), 1);
      wait_done(1);
      round(0, 0, 0, -50, 0, 0, -50, 5'b00000, 1'b1);

      repeat (4) @(negedge clk_SPI);
      chk("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
